// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store with LATENCY wait states.
// Optional fault detection is compiled in with DMEM_ERR_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  req_t req_q;
  logic accept, access, we;

  logic [31:0]      widx;
  logic [AW-1:0]    idx;
  logic [1:0]       off, esize;
  logic             fault;
  logic [3:0]       be;
  logic [3:0][7:0]  lane_d, rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data, rdata_nxt;

  // Address decode on the latched request: alignment, lane offset, fault.
  always_comb begin
    widx  = {2'b00, req_q.addr[31:2]};
    idx   = AW'(widx % 32'(DEPTH_WORDS));
    off   = req_q.addr[1:0];
    esize = req_q.size;
    fault = 1'b0;
`ifdef DMEM_ERR_EN
    case (req_q.size)
      2'b01:   fault = req_q.addr[0];
      2'b10:   fault = (req_q.addr[1:0] != 2'b00);
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if (widx >= 32'(DEPTH_WORDS)) fault = 1'b1;
`else
    case (req_q.size)
      2'b00:   off = req_q.addr[1:0];
      2'b01:   off = {req_q.addr[1], 1'b0};
      default: begin
        off   = 2'b00;
        esize = 2'b10;
      end
    endcase
`endif
  end

  always_comb begin
    case (esize)
      2'b00: begin
        be     = 4'b0001 << off;
        lane_d = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        lane_d = {2{req_q.wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        lane_d = req_q.wdata;
      end
    endcase
  end

  assign we = access && req_q.write && !fault;

  // One byte-wide array per lane so partial stores need no read-modify-write.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
      if (we && be[i]) mem[idx] <= lane_d[i];
    end
    assign rd_word[i] = mem[idx];
  end

  always_comb begin
    ld_byte = rd_word[off];
    ld_half = {rd_word[{off[1], 1'b1}], rd_word[{off[1], 1'b0}]};
    case (esize)
      2'b00:   ld_data = req_q.uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = req_q.uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
    rdata_nxt = (req_q.write || fault) ? 32'd0 : ld_data;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(LATENCY);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      rsp_rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept)
        req_q <= '{write: req_write, addr: req_addr, size: req_size,
                   uns: req_unsigned, wdata: req_wdata};
      if (access) rsp_rdata <= rdata_nxt;
    end
  end

`ifdef DMEM_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rsp_err <= 1'b0;
    else if (access) rsp_err <= fault;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the core's load/store port. Accepts one request at a time from the datapath (address from the ALU result, store data from the register file) and performs byte/half/word reads and writes on an internal word array. Returns load data to the core's read-data input after a configurable wait-state latency. The responder end of the core's memory interface; inserts real multi-cycle memory timing in place of a zero-latency model.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = req_addr[31:2]
- LATENCY, 2, wait states from request accept to response; legal range 1..15

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word; 11 reserved (treated as misaligned)
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  access faulted; valid only with rsp_valid

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/addr/size/unsigned/wdata, load counter with LATENCY, go WAIT.
- WAIT: req_ready=0. Counter decrements each edge; on the edge where counter==1, perform the access, register rsp_rdata/rsp_err, go RESP.
- RESP: rsp_valid=1, req_ready=0; rsp_rdata/rsp_err held stable. On rsp_valid&&rsp_ready go IDLE.
- Store: write only selected lanes. Byte → lane addr[1:0] gets wdata[7:0]; half → lanes {addr[1],0} and {addr[1],1} get wdata[15:0] (little-endian); word → all lanes.
- Load: extract lane(s) from addressed word, little-endian; sign- or zero-extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
- Fault conditions (with DMEM_ERR_EN): half with addr[0]=1; word with addr[1:0]≠0; size 11; word index ≥ DEPTH_WORDS. Fault → no array write, rsp_rdata=0, rsp_err=1.
- Memory contents are not reset; only control state and output registers.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, state IDLE.
- Request accepted at edge N → store committed and rsp_valid high at edge N+LATENCY.
- req_ready and rsp_valid are never both high; no request pipelining. Minimum request-to-request spacing LATENCY+1 cycles (rsp_ready tied 1).
- rsp_ready low holds RESP indefinitely with outputs stable.
- Load from a word stored by the immediately preceding request returns the new data.
- Reset asserted in WAIT: pending store is dropped, array unchanged. Reset asserted in RESP: response discarded, outputs to reset values.
- Request inputs are don't-care outside IDLE.

## Configuration
- DMEM_ERR_EN defined: fault detection as above, rsp_err driven.
- DMEM_ERR_EN undefined: rsp_err tied 0; addresses are forced aligned (half clears addr[0], word clears addr[1:0], size 11 treated as word); word index wraps modulo DEPTH_WORDS; every request performs its access.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10, LATENCY=2 → rsp_valid exactly 2 cycles after each accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store 0x80 to 0x11 then loads at 0x11: signed → 0xFFFFFF80, unsigned → 0x00000080; word load 0x10 → 0xDEAD80EF.
- Half store 0x1234 to 0x12, signed half load 0x12 → 0x00001234; word load 0x10 → 0x123480EF.
- DMEM_ERR_EN: word store to 0x13 → rsp_err=1, rsp_rdata=0; subsequent word load 0x10 unchanged (0x123480EF). Load at word index DEPTH_WORDS → rsp_err=1.
- Back-pressure: rsp_ready held 0 for 5 cycles in RESP → rsp_valid/rsp_rdata stable, req_ready=0; released → IDLE next cycle.
- Reset pulse during WAIT of a store 0x55AA55AA to 0x20 → outputs at reset values immediately; later load 0x20 returns prior contents.
